// File: rtl/mem_stage.sv
// mem_stage: memory-stage controller behind the EXE/MEM pipeline register.
// Executes LB/LH/LW/LBU/LHU/SB/SH/SW on a variable-latency req/ack data bus,
// forms byte enables, replicates store data across lanes, extends load data
// and presents registered writeback fields to MEM/WB.
// Ports:
//   clk_i, rst_i (sync, active-low)
//   reg_waddr_i/reg_we_i/reg_wdata_i : writeback fields from EXE/MEM
//   mem_we_i/mem_addr_i/mem_data_i/mem_op_i : memory access from EXE/MEM
//   reg_waddr_o/reg_we_o/reg_wdata_o : registered writeback fields to MEM/WB
//   stall_o    : combinational freeze of the upstream stages
//   misalign_o : one-cycle pulse, misaligned access dropped
//   bus_err_o  : one-cycle pulse, bus transaction aborted on timeout
//   bus_req_o/bus_we_o/bus_addr_o/bus_wdata_o/bus_be_o, bus_ack_i/bus_rdata_i : data bus
module mem_stage #(
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned RADDR_WIDTH = 5,
   parameter int unsigned TIMEOUT     = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
   input  logic                   reg_we_i,
   input  logic [DATA_WIDTH-1:0]  reg_wdata_i,
   input  logic                   mem_we_i,
   input  logic [ADDR_WIDTH-1:0]  mem_addr_i,
   input  logic [DATA_WIDTH-1:0]  mem_data_i,
   input  logic [3:0]             mem_op_i,
   output logic [RADDR_WIDTH-1:0] reg_waddr_o,
   output logic                   reg_we_o,
   output logic [DATA_WIDTH-1:0]  reg_wdata_o,
   output logic                   stall_o,
   output logic                   misalign_o,
   output logic                   bus_err_o,
   output logic                   bus_req_o,
   output logic                   bus_we_o,
   output logic [ADDR_WIDTH-1:0]  bus_addr_o,
   output logic [DATA_WIDTH-1:0]  bus_wdata_o,
   output logic [3:0]             bus_be_o,
   input  logic                   bus_ack_i,
   input  logic [DATA_WIDTH-1:0]  bus_rdata_i
);

   typedef enum logic {S_IDLE, S_BUSY} state_e;
   typedef enum logic [3:0] {
      OP_NOP = 4'd0, OP_LB  = 4'd1, OP_LH  = 4'd2, OP_LW = 4'd3, OP_LBU = 4'd4,
      OP_LHU = 4'd5, OP_SB  = 4'd6, OP_SH  = 4'd7, OP_SW = 4'd8
   } op_e;

   localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   state_e          state;
   op_e             op_q;
   logic [1:0]      lane_q;
   logic [CW-1:0]   cnt;

   logic [1:0]      lane;
   logic            is_load, is_store, is_byte, is_half, is_word, is_mem;
   logic            misaligned, expire;
   logic [3:0]      be;
   logic [DATA_WIDTH-1:0] st_data, ld_data;
   logic [7:0]      ld_byte;
   logic [15:0]     ld_half;

   // The store flag is implied by the opcode; mem_we_i is redundant with it.
   logic            unused_mem_we;
   assign unused_mem_we = mem_we_i;

   assign lane = mem_addr_i[1:0];

   always_comb begin
      is_load  = 1'b0;
      is_store = 1'b0;
      is_byte  = 1'b0;
      is_half  = 1'b0;
      is_word  = 1'b0;
      case (mem_op_i)
         OP_LB, OP_LBU: begin is_load  = 1'b1; is_byte = 1'b1; end
         OP_LH, OP_LHU: begin is_load  = 1'b1; is_half = 1'b1; end
         OP_LW:         begin is_load  = 1'b1; is_word = 1'b1; end
         OP_SB:         begin is_store = 1'b1; is_byte = 1'b1; end
         OP_SH:         begin is_store = 1'b1; is_half = 1'b1; end
         OP_SW:         begin is_store = 1'b1; is_word = 1'b1; end
         default:       ;
      endcase
   end

   assign is_mem     = is_load | is_store;
   assign misaligned = (is_half & lane[0]) | (is_word & (lane != 2'b00));

   always_comb begin
      be      = 4'b1111;
      st_data = mem_data_i;
      if (is_byte) begin
         be      = 4'b0001 << lane;
         st_data = {4{mem_data_i[7:0]}};
      end else if (is_half) begin
         be      = lane[1] ? 4'b1100 : 4'b0011;
         st_data = {2{mem_data_i[15:0]}};
      end
   end

   // Extraction uses the lane/opcode captured at issue, not the live inputs.
   always_comb begin
      case (lane_q)
         2'd0:    ld_byte = bus_rdata_i[7:0];
         2'd1:    ld_byte = bus_rdata_i[15:8];
         2'd2:    ld_byte = bus_rdata_i[23:16];
         default: ld_byte = bus_rdata_i[31:24];
      endcase
      ld_half = lane_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
      case (op_q)
         OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
         OP_LBU:  ld_data = {24'd0, ld_byte};
         OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
         OP_LHU:  ld_data = {16'd0, ld_half};
         default: ld_data = bus_rdata_i;
      endcase
   end

   assign expire = (cnt == CW'(TIMEOUT - 1));

   // On the final timeout cycle the abort is already decided, so upstream is released.
   assign stall_o = rst_i & (((state == S_IDLE) & is_mem & ~misaligned) |
                             ((state == S_BUSY) & ~bus_ack_i & ~expire));

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state       <= S_IDLE;
         op_q        <= OP_NOP;
         lane_q      <= '0;
         cnt         <= '0;
         reg_waddr_o <= '0;
         reg_we_o    <= 1'b0;
         reg_wdata_o <= '0;
         misalign_o  <= 1'b0;
         bus_err_o   <= 1'b0;
         bus_req_o   <= 1'b0;
         bus_we_o    <= 1'b0;
         bus_addr_o  <= '0;
         bus_wdata_o <= '0;
         bus_be_o    <= '0;
      end else begin
         misalign_o <= 1'b0;
         bus_err_o  <= 1'b0;
         case (state)
            S_IDLE: begin
               reg_waddr_o <= reg_waddr_i;
               reg_wdata_o <= reg_wdata_i;
               if (!is_mem) begin
                  reg_we_o <= reg_we_i;
               end else if (misaligned) begin
                  reg_we_o   <= 1'b0;
                  misalign_o <= 1'b1;
               end else begin
                  reg_we_o    <= 1'b0;
                  bus_req_o   <= 1'b1;
                  bus_we_o    <= is_store;
                  bus_addr_o  <= {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
                  bus_wdata_o <= st_data;
                  bus_be_o    <= be;
                  op_q        <= op_e'(mem_op_i);
                  lane_q      <= lane;
                  cnt         <= '0;
                  state       <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (bus_ack_i) begin
                  bus_req_o <= 1'b0;
                  state     <= S_IDLE;
                  if (op_q inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU}) begin
                     reg_we_o    <= reg_we_i;
                     reg_waddr_o <= reg_waddr_i;
                     reg_wdata_o <= ld_data;
                  end else begin
                     reg_we_o <= 1'b0;
                  end
               end else if (expire) begin
                  bus_req_o <= 1'b0;
                  bus_err_o <= 1'b1;
                  reg_we_o  <= 1'b0;
                  state     <= S_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
